// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache word requests onto a single-ported RAM and
// returns completions. The dcache normally wins; a streak counter bounds icache starvation.
module cache_mem_arbiter #(
    parameter int          MAX_DSTREAK = 4,
    parameter logic [31:0] ERR_WORD    = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err,
    output logic [1:0]  state_dbg
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] dstreak_q, dstreak_d;
    logic          bus_err_q, bus_err_d;

    logic d_req;
    logic streak_full;

    assign d_req       = dREN | dWEN;
    assign streak_full = (dstreak_q == SW'(MAX_DSTREAK));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        bus_err_d = bus_err_q;
        case (state_q)
            IDLE: begin
                // Streak only counts dcache wins that made a waiting icache wait longer.
                if (d_req && !(iREN && streak_full)) begin
                    state_d = DGRANT;
                    if (!iREN)
                        dstreak_d = '0;
                    else if (!streak_full)
                        dstreak_d = dstreak_q + SW'(1);
                end else if (iREN) begin
                    state_d   = IGRANT;
                    dstreak_d = '0;
                end
            end
            IGRANT: begin
                if (!iREN || ramstate == RAM_ACCESS)
                    state_d = IDLE;
                else if (ramstate == RAM_ERROR) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end
            end
            DGRANT: begin
                if (!d_req || ramstate == RAM_ACCESS)
                    state_d = IDLE;
                else if (ramstate == RAM_ERROR) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && ramstate == RAM_ACCESS) begin
                    iwait = 1'b0;
                    iload = ramload;
                end else if (iREN && ramstate == RAM_ERROR) begin
                    iwait = 1'b0;
                    iload = ERR_WORD;
                end
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (d_req && ramstate == RAM_ACCESS) begin
                    dwait = 1'b0;
                    dload = ramload;
                end else if (d_req && ramstate == RAM_ERROR) begin
                    dwait = 1'b0;
                    dload = ERR_WORD;
                end
            end
            default: ;
        endcase
    end

    assign bus_err   = bus_err_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops them whenever iwait/dwait goes low.
module tb_cache_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0]  state_dbg;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    int checks = 0;
    int errors = 0;

    // Bit 32 marks whether the load value is meaningful (clear for writes).
    logic [32:0] iexp_q[$];
    logic [32:0] dexp_q[$];

    logic [11:0] dpat, ipat;

    cache_mem_arbiter #(.MAX_DSTREAK(4), .ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        logic [32:0] e;
        if (nRST === 1'b1) begin
            checks++;
            if (ramREN && ramWEN) begin
                errors++;
                $display("FAIL ram_enables: ramREN and ramWEN both high");
            end
            if (iwait === 1'b0) begin
                checks++;
                if (iexp_q.size() == 0) begin
                    errors++;
                    $display("FAIL icache_completion: unexpected iwait low, iload %h", iload);
                end else begin
                    e = iexp_q.pop_front();
                    if (e[32] && iload !== e[31:0]) begin
                        errors++;
                        $display("FAIL iload: got %h expected %h", iload, e[31:0]);
                    end
                end
            end
            if (dwait === 1'b0) begin
                checks++;
                if (dexp_q.size() == 0) begin
                    errors++;
                    $display("FAIL dcache_completion: unexpected dwait low, dload %h", dload);
                end else begin
                    e = dexp_q.pop_front();
                    if (e[32] && dload !== e[31:0]) begin
                        errors++;
                        $display("FAIL dload: got %h expected %h", dload, e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        nRST = 1'b0;
        iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        ramload = 32'h0; ramstate = ACCESS;

        // Reset holds everything quiet even with requests raised.
        settle();
        chk("rst iwait", iwait, 1);
        chk("rst dwait", dwait, 1);
        chk("rst ramREN", ramREN, 0);
        chk("rst ramWEN", ramWEN, 0);
        chk("rst bus_err", bus_err, 0);
        chk("rst ramaddr", ramaddr, 0);
        chk("rst iload", iload, 0);
        iREN = 1'b0; dREN = 1'b0;
        step();
        nRST = 1'b1;

        // Single icache read, RAM answers on the second grant cycle.
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
        settle();
        chk("rd idle ramREN", ramREN, 0);
        step();
        settle();
        chk("rd grant1 ramREN", ramREN, 1);
        chk("rd grant1 ramaddr", ramaddr, 32'h40);
        chk("rd grant1 iwait", iwait, 1);
        step();
        ramstate = ACCESS; ramload = 32'h8C220004;
        iexp_q.push_back({1'b1, 32'h8C220004});
        settle();
        chk("rd grant2 ramREN", ramREN, 1);
        step();
        iREN = 1'b0; ramstate = BUSY;
        settle();
        chk("rd after iwait", iwait, 1);
        chk("rd after ramREN", ramREN, 0);
        chk("rd after state", state_dbg, 0);
        step();

        // Contention: dcache write wins, icache served afterwards.
        iREN = 1'b1; iaddr = 32'h80;
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        settle();
        step();
        ramstate = ACCESS;
        dexp_q.push_back({1'b0, 32'h0});
        settle();
        chk("cont ramWEN", ramWEN, 1);
        chk("cont ramREN", ramREN, 0);
        chk("cont ramaddr", ramaddr, 32'h100);
        chk("cont ramstore", ramstore, 32'hDEADBEEF);
        chk("cont iwait", iwait, 1);
        step();
        dWEN = 1'b0; ramstate = BUSY;
        settle();
        chk("cont idle iwait", iwait, 1);
        chk("cont idle ramREN", ramREN, 0);
        step();
        ramstate = ACCESS; ramload = 32'h11112222;
        iexp_q.push_back({1'b1, 32'h11112222});
        settle();
        chk("cont igrant ramaddr", ramaddr, 32'h80);
        chk("cont igrant ramREN", ramREN, 1);
        step();
        iREN = 1'b0;
        settle();
        step();

        // Starvation bound: four dcache completions, one icache, then dcache.
        iREN = 1'b1; iaddr = 32'h300; dREN = 1'b1; daddr = 32'h200;
        ramstate = ACCESS; ramload = 32'hCAFE0001;
        dpat = 12'b1000_1010_1010;
        ipat = 12'b0010_0000_0000;
        for (int k = 0; k < 12; k++) begin
            if (dpat[k]) dexp_q.push_back({1'b1, 32'hCAFE0001});
            if (ipat[k]) iexp_q.push_back({1'b1, 32'hCAFE0001});
            settle();
            chk($sformatf("starve dwait c%0d", k), {31'b0, dwait}, {31'b0, ~dpat[k]});
            chk($sformatf("starve iwait c%0d", k), {31'b0, iwait}, {31'b0, ~ipat[k]});
            step();
        end
        iREN = 1'b0; dREN = 1'b0;
        settle();
        step();

        // Abandon: icache drops while RAM is busy, pending dcache read follows.
        iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY;
        settle();
        step();
        dREN = 1'b1; daddr = 32'h48;
        settle();
        chk("abn grant ramREN", ramREN, 1);
        step();
        iREN = 1'b0;
        settle();
        chk("abn drop ramREN", ramREN, 0);
        chk("abn drop iwait", iwait, 1);
        chk("abn drop dwait", dwait, 1);
        step();
        settle();
        chk("abn idle state", state_dbg, 0);
        step();
        ramstate = ACCESS; ramload = 32'h77778888;
        dexp_q.push_back({1'b1, 32'h77778888});
        settle();
        chk("abn dgrant ramREN", ramREN, 1);
        chk("abn dgrant ramaddr", ramaddr, 32'h48);
        step();
        dREN = 1'b0;
        settle();
        step();

        // Error completion sets the sticky flag.
        dREN = 1'b1; daddr = 32'h60; ramstate = ERROR;
        settle();
        chk("err before bus_err", bus_err, 0);
        step();
        dexp_q.push_back({1'b1, 32'hBAD1BAD1});
        settle();
        step();
        dREN = 1'b0;
        settle();
        chk("err after bus_err", bus_err, 1);
        step();
        iREN = 1'b1; iaddr = 32'h64; ramstate = ACCESS;
        settle();
        step();
        ramload = 32'h12345678;
        iexp_q.push_back({1'b1, 32'h12345678});
        settle();
        step();
        iREN = 1'b0;
        settle();
        chk("err sticky bus_err", bus_err, 1);
        step();

        // Reset in the middle of a dcache grant.
        dREN = 1'b1; daddr = 32'h70; ramstate = BUSY;
        settle();
        step();
        settle();
        chk("mid grant ramREN", ramREN, 1);
        #1;
        nRST = 1'b0;
        #1;
        chk("mid rst ramREN", ramREN, 0);
        chk("mid rst dwait", dwait, 1);
        chk("mid rst bus_err", bus_err, 0);
        chk("mid rst ramaddr", ramaddr, 0);
        dREN = 1'b0;
        step();
        nRST = 1'b1;
        settle();
        step();

        chk("iexp drained", iexp_q.size(), 0);
        chk("dexp drained", dexp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
